pc_stack: RTL and testbench

Program counter with hardware return-address stack for the 8-bit CPU model. Sits directly upstream of the memory address register: its 6-bit `Dout` drives the MAR program-address input each instruction fetch. Supports increment, absolute jump from the 8-bit data bus, and CALL/RET through a small LIFO of return addresses, with sticky overflow/underflow detection.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_stack_if.sv | 22 ++
 rtl/ret_stack.sv | 50 +++++
 rtl/pc_stack.sv | 69 ++++++
 tb/tb_pc_stack.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU model: default widths and the PC operation decode.
package cpu_pkg;

  localparam int unsigned AW_DEF    = 6;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LD,
    OP_CALL,
    OP_RET
  } pc_op_t;

  // Fixed-priority strobe decode: RET > CALL > PCLD > PCINC.
  function automatic pc_op_t pc_decode(input logic ret, input logic call,
                                       input logic ld, input logic inc);
    pc_op_t op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (ld)   op = OP_LD;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Strobe/data bundle between the sequencer and the program counter.
interface pc_stack_if #(
  parameter int unsigned AW    = cpu_pkg::AW_DEF,
  parameter int unsigned DW    = cpu_pkg::DW_DEF,
  parameter int unsigned DEPTH = cpu_pkg::DEPTH_DEF
);
  localparam int unsigned SPW = $clog2(DEPTH) + 1;

  logic           PCINC;
  logic           PCLD;
  logic           CALL;
  logic           RET;
  logic [DW-1:0]  Din;
  logic [AW-1:0]  Dout;
  logic [SPW-1:0] SP;
  logic           STKERR;

  modport master (output PCINC, PCLD, CALL, RET, Din,
                  input  Dout, SP, STKERR);
  modport slave  (input  PCINC, PCLD, CALL, RET, Din,
                  output Dout, SP, STKERR);
endinterface

// File: rtl/ret_stack.sv
// DEPTH x AW LIFO of return addresses; entries and count clear on reset.
module ret_stack #(
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              wdata,
  output logic [AW-1:0]              top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_c, rptr_c;
  logic          do_push_c, do_pop_c;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign wptr_c    = count_q[PW-1:0];
  // With count 0 this wraps to the last slot; callers never pop an empty stack.
  assign rptr_c    = wptr_c - PW'(1);
  assign top       = mem_q[rptr_c];
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push_c && !do_pop_c)      count_d = count_q + CW'(1);
    else if (do_pop_c && !do_push_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else begin
      if (do_push_c) mem_q[wptr_c] <= wdata;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with CALL/RET return-address stack and sticky stack-error flag.
module pc_stack
  import cpu_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  pc_stack_if.slave  bus
);
  localparam int unsigned SPW = $clog2(DEPTH) + 1;

  pc_op_t         op_c;
  logic [AW-1:0]  pc_q, pc_d;
  logic           err_q, err_d;
  logic [AW-1:0]  pc_inc_c, target_c, top_c;
  logic [SPW-1:0] count_c;
  logic           full_c, empty_c, push_c, pop_c;
  logic           unused_din;

  assign op_c       = pc_decode(bus.RET, bus.CALL, bus.PCLD, bus.PCINC);
  assign pc_inc_c   = pc_q + AW'(1);
  assign target_c   = bus.Din[AW-1:0];
  assign unused_din = ^bus.Din[DW-1:AW];
  assign push_c     = (op_c == OP_CALL) && !full_c;
  assign pop_c      = (op_c == OP_RET) && !empty_c;

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (pc_inc_c),
    .top   (top_c),
    .count (count_c),
    .full  (full_c),
    .empty (empty_c)
  );

  // Overflowing CALL and underflowing RET leave PC alone and only raise the error.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    case (op_c)
      OP_INC:  pc_d = pc_inc_c;
      OP_LD:   pc_d = target_c;
      OP_CALL: if (full_c)  err_d = 1'b1; else pc_d = target_c;
      OP_RET:  if (empty_c) err_d = 1'b1; else pc_d = top_c;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.Dout   = pc_q;
  assign bus.SP     = count_c;
  assign bus.STKERR = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed table-driven bench for pc_stack, plus reset/underflow corner sequences.
module tb_pc_stack;

  typedef struct {
    logic       inc;
    logic       ld;
    logic       call;
    logic       ret;
    logic [7:0] din;
    logic [5:0] exp_pc;
    logic [2:0] exp_sp;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  vec_t vq[$];

  pc_stack_if bus ();

  pc_stack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [5:0] pc,
                       input logic [2:0] sp, input logic err);
    n_checks++;
    if (bus.Dout === pc && bus.SP === sp && bus.STKERR === err) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got Dout=%0d SP=%0d STKERR=%0b, want Dout=%0d SP=%0d STKERR=%0b",
               name, idx, bus.Dout, bus.SP, bus.STKERR, pc, sp, err);
    end
  endtask

  task automatic drive(input logic inc, input logic ld, input logic call,
                       input logic ret, input logic [7:0] din);
    bus.PCINC = inc;
    bus.PCLD  = ld;
    bus.CALL  = call;
    bus.RET   = ret;
    bus.Din   = din;
  endtask

  task automatic add(input logic inc, input logic ld, input logic call, input logic ret,
                     input logic [7:0] din, input logic [5:0] pc, input logic [2:0] sp,
                     input logic err);
    vec_t v;
    v.inc = inc; v.ld = ld; v.call = call; v.ret = ret; v.din = din;
    v.exp_pc = pc; v.exp_sp = sp; v.exp_err = err;
    vq.push_back(v);
  endtask

  // Drive one vector, let one edge sample it, compare just after the edge.
  task automatic step(input string name, input int idx, input vec_t v);
    drive(v.inc, v.ld, v.call, v.ret, v.din);
    @(posedge clk);
    #1;
    check(name, idx, v.exp_pc, v.exp_sp, v.exp_err);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) step(name, i, vq[i]);
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold", 0, 6'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;

    //   inc  ld   call ret  din     pc     sp    err
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1,  3'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd2,  3'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd3,  3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 6'd63, 3'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0,  3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'd5,  6'd5,  3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 6'd40, 3'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd41, 3'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd42, 3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd6,  3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  6'd0,  3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 6'd10, 3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd20, 6'd20, 3'd2, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd30, 6'd30, 3'd3, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 6'd40, 3'd4, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd50, 6'd40, 3'd4, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd31, 3'd3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd21, 3'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd11, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd1,  3'd0, 1'b1);
    run_table("basic");

    do_reset();
    check("reset_clears_err", 0, 6'd0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'd16, 6'd16, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  6'd0,  3'd1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'd33, 6'd17, 3'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'd9,  6'd9,  3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'd2,  6'd2,  3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 6'd2,  3'd1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'd63, 6'd63, 3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'hC5, 6'd5,  3'd2, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd0,  3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd10, 3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 6'd10, 3'd0, 1'b0);
    run_table("priority");

    do_reset();
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd0,  3'd0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1,  3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd20, 6'd20, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd30, 6'd30, 3'd2, 1'b1);
    run_table("underflow");

    // Asynchronous reset between edges, held across an edge with strobes active.
    #2;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd44);
    rst = 1'b0;
    #1;
    check("async_reset", 0, 6'd0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 0, 6'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'd7,  6'd7,  3'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd1,  3'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd1,  3'd0, 1'b1);
    run_table("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
